// File: rtl/cr_tcipif_pkg.sv
// ----------------------------------------------------------------------------
// cr_tcipif_pkg
// Shared definitions for the TCIP data-bus router and its address decoder:
//   - 2-bit FSM state codes and the state enum built on them
//   - dbus access size codes
//   - default value of the TCIP region tag (dbus addr[31:16])
// ----------------------------------------------------------------------------
package cr_tcipif_pkg;

    // FSM state codes. IDLE is 0 so a reset debug view reads as all-zero.
    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_ACCESS = 2'd1;
    localparam logic [1:0] STATE_RESP   = 2'd2;
    localparam logic [1:0] STATE_ERR    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = STATE_IDLE,
        ST_ACCESS = STATE_ACCESS,
        ST_RESP   = STATE_RESP,
        ST_ERR    = STATE_ERR
    } tcip_state_e;

    // dbus size codes
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Upper address half that marks the TCIP region
    localparam logic [15:0] TCIP_BASE_HI_DFLT = 16'hE000;

endpackage

// File: rtl/cr_tcipif_addr_dec.sv
// ----------------------------------------------------------------------------
// cr_tcipif_addr_dec
// Combinational window decoder for TCIP slaves. Written bus-agnostic so an
// ibus router can reuse it.
//
// Ports:
//   addr        in   32        byte address
//   supv_mode   in   1         1 = supervisor/machine access
//   acc_deny    in   1         MPU denial, always an error
//   hit_onehot  out  NUM_SLV   one-hot winning window (lowest index wins)
//   dec_err     out  1         deny | no window | user access to supv-only slave
// ----------------------------------------------------------------------------
module cr_tcipif_addr_dec
    import cr_tcipif_pkg::*;
#(
    parameter int                    NUM_SLV       = 4,
    parameter logic [15:0]           TCIP_BASE_HI  = TCIP_BASE_HI_DFLT,
    parameter logic [NUM_SLV*16-1:0] SLV_BASE      = {NUM_SLV{16'h0}},
    parameter logic [NUM_SLV*16-1:0] SLV_MASK      = {NUM_SLV{16'hF000}},
    parameter logic [NUM_SLV-1:0]    SLV_SUPV_ONLY = {NUM_SLV{1'b1}}
) (
    input  logic [31:0]        addr,
    input  logic               supv_mode,
    input  logic               acc_deny,
    output logic [NUM_SLV-1:0] hit_onehot,
    output logic               dec_err
);

    logic region_ok;
    logic found;
    logic supv_err;

    assign region_ok = (addr[31:16] == TCIP_BASE_HI);

    // Priority encode: the first matching window claims the access, so
    // overlapping windows never yield more than one select bit.
    always_comb begin
        hit_onehot = '0;
        found      = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (!found && region_ok &&
                ((addr[15:0] & SLV_MASK[16*i +: 16]) ==
                 (SLV_BASE[16*i +: 16] & SLV_MASK[16*i +: 16]))) begin
                hit_onehot[i] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    assign supv_err = (|(hit_onehot & SLV_SUPV_ONLY)) & ~supv_mode;
    assign dec_err  = acc_deny | ~found | supv_err;

endmodule

// File: rtl/cr_tcipif_dbus_router.sv
// ----------------------------------------------------------------------------
// cr_tcipif_dbus_router
// Routes one BMU dbus transaction at a time to one of NUM_SLV TCIP slaves.
//
// Handshake: the BMU holds req with stable fields until grnt; grnt is only
// asserted in IDLE and is the single combinational output. After a grant the
// BMU waits for a one-cycle trans_cmplt strobe (with data_vld / acc_err) before
// the next request can be granted. Slaves see a registered one-hot sel held
// until they pulse their cmplt bit; cmplt from an unselected slave is ignored.
//
// Ports:
//   forever_cpuclk / cpurst_b         clock, async active-low reset
//   bmu_tcipif_dbus_*                 request side from the BMU
//   tcipif_bmu_dbus_*                 grant and response back to the BMU
//   tcipif_slv_*                      select and latched command to slaves
//   slv_tcipif_cmplt / _rdata         per-slave completion and read data
//   tcipif_timeout                    pulse when a slave failed to complete
//   tcipif_dbg_state                  current FSM state (cr_tcipif_pkg codes)
// ----------------------------------------------------------------------------
module cr_tcipif_dbus_router
    import cr_tcipif_pkg::*;
#(
    parameter int                    NUM_SLV       = 4,
    parameter logic [15:0]           TCIP_BASE_HI  = TCIP_BASE_HI_DFLT,
    parameter logic [NUM_SLV*16-1:0] SLV_BASE      = {NUM_SLV{16'h0}},
    parameter logic [NUM_SLV*16-1:0] SLV_MASK      = {NUM_SLV{16'hF000}},
    parameter logic [NUM_SLV-1:0]    SLV_SUPV_ONLY = {NUM_SLV{1'b1}},
    parameter int                    TIMEOUT_CYC   = 255,
    parameter int                    CNT_W         = 8
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    bmu_tcipif_dbus_req,
    input  logic [31:0]             bmu_tcipif_dbus_addr,
    input  logic [1:0]              bmu_tcipif_dbus_size,
    input  logic                    bmu_tcipif_dbus_write,
    input  logic [31:0]             bmu_tcipif_dbus_wdata,
    input  logic                    bmu_tcipif_dbus_supv_mode,
    input  logic                    bmu_tcipif_dbus_acc_deny,
    output logic                    tcipif_bmu_dbus_grnt,
    output logic                    tcipif_bmu_dbus_trans_cmplt,
    output logic                    tcipif_bmu_dbus_data_vld,
    output logic [31:0]             tcipif_bmu_dbus_data,
    output logic                    tcipif_bmu_dbus_acc_err,
    output logic [NUM_SLV-1:0]      tcipif_slv_sel,
    output logic [15:0]             tcipif_slv_addr,
    output logic                    tcipif_slv_write,
    output logic [1:0]              tcipif_slv_size,
    output logic [31:0]             tcipif_slv_wdata,
    input  logic [NUM_SLV-1:0]      slv_tcipif_cmplt,
    input  logic [NUM_SLV*32-1:0]   slv_tcipif_rdata,
    output logic                    tcipif_timeout,
    output logic [1:0]              tcipif_dbg_state
);

    localparam bit              TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    tcip_state_e         state_q, state_d;
    logic [NUM_SLV-1:0]  sel_q, sel_d;
    logic [15:0]         addr_q, addr_d;
    logic                write_q, write_d;
    logic [1:0]          size_q, size_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cmplt_q, cmplt_d;
    logic                vld_q, vld_d;
    logic [31:0]         data_q, data_d;
    logic                err_q, err_d;
    logic                to_q, to_d;

    logic [NUM_SLV-1:0]  dec_hit;
    logic                dec_err;
    logic                sel_cmplt;
    logic [31:0]         sel_rdata;

    cr_tcipif_addr_dec #(
        .NUM_SLV       (NUM_SLV),
        .TCIP_BASE_HI  (TCIP_BASE_HI),
        .SLV_BASE      (SLV_BASE),
        .SLV_MASK      (SLV_MASK),
        .SLV_SUPV_ONLY (SLV_SUPV_ONLY)
    ) u_addr_dec (
        .addr       (bmu_tcipif_dbus_addr),
        .supv_mode  (bmu_tcipif_dbus_supv_mode),
        .acc_deny   (bmu_tcipif_dbus_acc_deny),
        .hit_onehot (dec_hit),
        .dec_err    (dec_err)
    );

    // sel_q is one-hot (or zero), so an AND-OR mux is enough.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | slv_tcipif_rdata[32*i +: 32];
            end
        end
    end

    assign sel_cmplt = |(slv_tcipif_cmplt & sel_q);

    // Response strobes default low every cycle; they are set only on the
    // transition into RESP/ERR so they appear for exactly that one cycle.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        cmplt_d = 1'b0;
        vld_d   = 1'b0;
        data_d  = '0;
        err_d   = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bmu_tcipif_dbus_req) begin
                    addr_d  = bmu_tcipif_dbus_addr[15:0];
                    write_d = bmu_tcipif_dbus_write;
                    size_d  = bmu_tcipif_dbus_size;
                    wdata_d = bmu_tcipif_dbus_wdata;
                    if (dec_err) begin
                        state_d = ST_ERR;
                        cmplt_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                        sel_d   = dec_hit;
                    end
                end
            end
            ST_ACCESS: begin
                // Completion is checked first so it beats a same-cycle timeout.
                if (sel_cmplt) begin
                    state_d = ST_RESP;
                    sel_d   = '0;
                    cnt_d   = '0;
                    cmplt_d = 1'b1;
                    vld_d   = ~write_q;
                    data_d  = write_q ? 32'h0 : sel_rdata;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    // Timeout pulse is registered, so it lines up with the
                    // error strobe in the ERR cycle.
                    state_d = ST_ERR;
                    sel_d   = '0;
                    cnt_d   = '0;
                    cmplt_d = 1'b1;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            cmplt_q <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            cmplt_q <= cmplt_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    assign tcipif_bmu_dbus_grnt        = (state_q == ST_IDLE) & bmu_tcipif_dbus_req;
    assign tcipif_bmu_dbus_trans_cmplt = cmplt_q;
    assign tcipif_bmu_dbus_data_vld    = vld_q;
    assign tcipif_bmu_dbus_data        = data_q;
    assign tcipif_bmu_dbus_acc_err     = err_q;
    assign tcipif_slv_sel              = sel_q;
    assign tcipif_slv_addr             = addr_q;
    assign tcipif_slv_write            = write_q;
    assign tcipif_slv_size             = size_q;
    assign tcipif_slv_wdata            = wdata_q;
    assign tcipif_timeout              = to_q;
    assign tcipif_dbg_state            = state_q;

endmodule

// File: doc/cr_tcipif_dbus_router.md
Name: cr_tcipif_dbus_router

Overview:
Parametrised data-bus router for the tightly-coupled IP interface (TCIP) of the E902 core. It accepts one BMU dbus transaction at a time and decodes it against NUM_SLV configurable address windows. It drives a one-hot select to the matching TCIP slave (CLIC, core timer, HAD, future IPs) and returns a registered response. It adds supervisor-only windows, unmapped-address errors and a completion timeout, none of which the fixed three-slave decoder has.

Parameters:
NUM_SLV, 4, number of TCIP slave channels (1..8)
TCIP_BASE_HI, 16'hE000, required value of dbus addr[31:16]; any other value is unmapped
SLV_BASE, {NUM_SLV{16'h0}}, packed per-slave 16-bit window base, compared on addr[15:0]
SLV_MASK, {NUM_SLV{16'hF000}}, packed per-slave 16-bit compare mask (1 = bit compared)
SLV_SUPV_ONLY, {NUM_SLV{1'b1}}, per-slave bit; 1 = user-mode access is an error
TIMEOUT_CYC, 255, ACCESS cycles allowed before an error response; 0 disables the timeout
CNT_W, 8, timeout counter width; must satisfy TIMEOUT_CYC < 2^CNT_W

Ports:
forever_cpuclk  in  1  core clock
cpurst_b  in  1  asynchronous active-low reset
bmu_tcipif_dbus_req  in  1  request valid
bmu_tcipif_dbus_addr  in  32  byte address
bmu_tcipif_dbus_size  in  2  0=byte, 1=half, 2=word
bmu_tcipif_dbus_write  in  1  1 = write
bmu_tcipif_dbus_wdata  in  32  write data
bmu_tcipif_dbus_supv_mode  in  1  1 = supervisor/machine access
bmu_tcipif_dbus_acc_deny  in  1  MPU denial; forces an error
tcipif_bmu_dbus_grnt  out  1  request accepted this cycle
tcipif_bmu_dbus_trans_cmplt  out  1  one-cycle response strobe
tcipif_bmu_dbus_data_vld  out  1  read data valid, coincident with cmplt
tcipif_bmu_dbus_data  out  32  read data
tcipif_bmu_dbus_acc_err  out  1  error response, coincident with cmplt
tcipif_slv_sel  out  NUM_SLV  one-hot slave select
tcipif_slv_addr  out  16  latched addr[15:0]
tcipif_slv_write  out  1  latched write
tcipif_slv_size  out  2  latched size
tcipif_slv_wdata  out  32  latched wdata
slv_tcipif_cmplt  in  NUM_SLV  per-slave completion
slv_tcipif_rdata  in  NUM_SLV*32  per-slave read data, slave i at [32i+31:32i]
tcipif_timeout  out  1  one-cycle pulse when a timeout fires

Behaviour:
- Reset value of every output is 0. The FSM resets to IDLE and the timeout counter to 0. Reset mid-transaction drops the transaction; no response is issued.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - grnt = req, combinational. It is the only combinational output and is 0 in every other state.
  - On grant, latch addr[15:0], write, size and wdata.
  - Hit i = (addr[31:16]==TCIP_BASE_HI) & ((addr[15:0] & MASK_i) == (BASE_i & MASK_i)).
  - If several windows hit, the lowest index wins.
  - Error condition = acc_deny | no hit | (SLV_SUPV_ONLY[i] & ~supv_mode). On error go to ERR; otherwise go to ACCESS with sel[i] registered high.
- ACCESS:
  - sel, addr, write, size and wdata are held stable.
  - On slv_tcipif_cmplt[i] for the selected i: capture rdata_i (zero on a write), clear sel, go to RESP.
  - cmplt from unselected slaves is ignored.
  - The counter increments each ACCESS cycle without cmplt. When counter == TIMEOUT_CYC-1 and no cmplt: clear sel, pulse tcipif_timeout, go to ERR.
  - cmplt in the same cycle as the timeout threshold wins; the transfer completes normally.
- RESP: trans_cmplt=1, data_vld = ~write, data = captured value, for one cycle; then IDLE.
- ERR: trans_cmplt=1, acc_err=1, data=0, data_vld=0, for one cycle; then IDLE. The counter clears.
- Latency, grant at cycle T:
  - sel high at T+1; a slave completing at T+1 gives a response at T+2 (minimum).
  - A decode error gives a response at T+1.
- A late cmplt arriving after a timeout, in RESP/ERR/IDLE, is ignored.
- Back-to-back: a new request can be granted in the cycle after RESP/ERR.
- Exactly one transaction is outstanding at a time.

Decomposition:
- Package cr_tcipif_pkg: FSM state encoding (2-bit localparams), size encodings, TCIP_BASE_HI default.
- Sub-module cr_tcipif_addr_dec: combinational window match, priority encoder and supervisor check. Outputs a one-hot hit vector and an error flag. It is reusable for a future ibus router.

Test Plan:
- NUM_SLV=4, SLV_BASE[1]=16'h1000, read 0xE000_1004 with supv=1; slave 1 completes 3 cycles after sel with rdata 32'hA5A5_0001 -> sel=4'b0010, response at grant+5 with data_vld=1, data=32'hA5A5_0001, acc_err=0.
- Write 0xE000_1008 with wdata 32'h1234_5678; slave 1 completes at once -> slv_wdata=32'h1234_5678 while sel is high, cmplt at grant+2, data_vld=0.
- Requests to 0xE100_0000 (wrong base) and 0xE000_F000 (no window) -> no sel, acc_err=1 at grant+1, data=0.
- SLV_SUPV_ONLY[1]=1 with supv=0; and, separately, acc_deny=1 on a valid address -> acc_err=1 at grant+1, no sel in either case.
- TIMEOUT_CYC=4 and the slave never completes -> sel high for 4 cycles, tcipif_timeout pulses once, acc_err=1 next cycle; a late cmplt after that is ignored.
- Assert reset during ACCESS -> all outputs 0 and FSM in IDLE; the next request is granted and served normally.
